// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath (master) supplies register indices and stage status; the
// controller (slave) returns register enables/flushes plus status.
interface pipe_hazard_ctrl_if;
  // ID stage
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic        branch_d;
  logic        branch_taken_d;
  logic        jump_d;
  // EX stage
  logic [4:0]  rt_e;
  logic [4:0]  writereg_e;
  logic        memtoreg_e;
  logic        regwrite_e;
  logic        md_start_e;
  // MEM stage
  logic [4:0]  writereg_m;
  logic        memtoreg_m;
  logic        dmem_req_m;
  // Unit status / control
  logic        md_done;
  logic        dmem_ready;
  logic        cnt_clr;
  // Pipeline register controls
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  // Status
  logic [1:0]  state;
  logic        md_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output rs_d, rt_d, branch_d, branch_taken_d, jump_d,
           rt_e, writereg_e, memtoreg_e, regwrite_e, md_start_e,
           writereg_m, memtoreg_m, dmem_req_m,
           md_done, dmem_ready, cnt_clr,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           state, md_timeout, stall_cycles
  );

  modport slave (
    input  rs_d, rt_d, branch_d, branch_taken_d, jump_d,
           rt_e, writereg_e, memtoreg_e, regwrite_e, md_start_e,
           writereg_m, memtoreg_m, dmem_req_m,
           md_done, dmem_ready, cnt_clr,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           state, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline with a multi-cycle MDU.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | pipeline flowing; an MDU start in EX stalls and enters MD_BUSY
// MD_BUSY | waiting for md_done, bounded by MD_TIMEOUT cycles
// 2'd2/3  | unreachable; recovers to RUN on the next edge
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    ILL2    = 2'd2,
    ILL3    = 2'd3
  } state_e;

  // Last busy_cnt value before the wait is abandoned.
  localparam logic [7:0] BUSY_LAST = 8'(MD_TIMEOUT - 1);

  state_e      state_q,        state_d;
  logic [7:0]  busy_cnt_q,     busy_cnt_d;
  logic        md_timeout_q,   md_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic mem_stall;
  logic md_stall;
  logic lu_stall;
  logic br_stall;
  logic e_fwd_hit;
  logic m_fwd_hit;
  logic redirect;
  logic any_stall;

  // Hazard detection terms
  assign mem_stall = bus.dmem_req_m & ~bus.dmem_ready;

  assign md_stall  = ((state_q == RUN) & bus.md_start_e) |
                     ((state_q == MD_BUSY) & ~bus.md_done & (busy_cnt_q < BUSY_LAST));

  assign lu_stall  = bus.memtoreg_e & (bus.rt_e != 5'd0) &
                     ((bus.rt_e == bus.rs_d) | (bus.rt_e == bus.rt_d));

  // Branches resolve in ID, so a result still in EX, or a load still in MEM,
  // cannot be forwarded to the comparator in time.
  assign e_fwd_hit = bus.regwrite_e & (bus.writereg_e != 5'd0) &
                     ((bus.writereg_e == bus.rs_d) | (bus.writereg_e == bus.rt_d));
  assign m_fwd_hit = bus.memtoreg_m & (bus.writereg_m != 5'd0) &
                     ((bus.writereg_m == bus.rs_d) | (bus.writereg_m == bus.rt_d));
  assign br_stall  = bus.branch_d & (e_fwd_hit | m_fwd_hit);

  assign redirect  = bus.branch_taken_d | bus.jump_d;
  assign any_stall = mem_stall | md_stall | lu_stall | br_stall;

  // Pipeline enables/flushes by stall priority; everything held low in reset
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.idex_en     = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.memwb_en    = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.memwb_flush = 1'b0;
    if (reset_n) begin
      if (mem_stall) begin
        // Freeze everything up to MEM; WB receives a bubble.
        bus.memwb_en    = 1'b1;
        bus.memwb_flush = 1'b1;
      end else if (md_stall) begin
        // Hold the MDU op in EX; MEM receives a bubble.
        bus.exmem_en    = 1'b1;
        bus.exmem_flush = 1'b1;
        bus.memwb_en    = 1'b1;
      end else if (lu_stall | br_stall) begin
        // Hold IF/ID; EX receives a bubble.
        bus.idex_en     = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.memwb_en    = 1'b1;
      end else begin
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = redirect;
      end
    end
  end

  // MDU wait FSM next-state, busy counter and sticky timeout
  always_comb begin
    state_d      = state_q;
    busy_cnt_d   = busy_cnt_q;
    md_timeout_d = md_timeout_q;
    case (state_q)
      RUN: begin
        // md_done outside MD_BUSY carries no meaning and is ignored.
        if (bus.md_start_e & ~mem_stall) begin
          state_d    = MD_BUSY;
          busy_cnt_d = 8'd0;
        end
      end
      MD_BUSY: begin
        if (!mem_stall) begin
          if (bus.md_done) begin
            // A result arriving on the last allowed cycle is not a timeout.
            state_d = RUN;
          end else if (busy_cnt_q == BUSY_LAST) begin
            state_d      = RUN;
            md_timeout_d = 1'b1;
          end else begin
            busy_cnt_d = busy_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stall performance counter: saturating, clear wins over increment
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bus.cnt_clr) begin
      stall_cycles_d = 16'd0;
    end else if (any_stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      busy_cnt_q     <= 8'd0;
      md_timeout_q   <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      busy_cnt_q     <= busy_cnt_d;
      md_timeout_q   <= md_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.md_timeout   = md_timeout_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with the default MDU
// timeout and one with MD_TIMEOUT=4, both fed the same stimulus.
module tb_pipe_hazard_ctrl;

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  localparam logic [8:0] C_OFF  = 9'b00000_0000;
  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_RDR  = 9'b11111_1000;
  localparam logic [8:0] C_MEM  = 9'b00001_0001;
  localparam logic [8:0] C_MD   = 9'b00011_0010;
  localparam logic [8:0] C_HZ   = 9'b00111_0100;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  logic [15:0] exp_sc;

  pipe_hazard_ctrl_if if64 ();
  pipe_hazard_ctrl_if if4 ();

  pipe_hazard_ctrl #(.MD_TIMEOUT(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(if64.slave));
  pipe_hazard_ctrl #(.MD_TIMEOUT(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(if4.slave));

  assign if4.rs_d           = if64.rs_d;
  assign if4.rt_d           = if64.rt_d;
  assign if4.branch_d       = if64.branch_d;
  assign if4.branch_taken_d = if64.branch_taken_d;
  assign if4.jump_d         = if64.jump_d;
  assign if4.rt_e           = if64.rt_e;
  assign if4.writereg_e     = if64.writereg_e;
  assign if4.memtoreg_e     = if64.memtoreg_e;
  assign if4.regwrite_e     = if64.regwrite_e;
  assign if4.md_start_e     = if64.md_start_e;
  assign if4.writereg_m     = if64.writereg_m;
  assign if4.memtoreg_m     = if64.memtoreg_m;
  assign if4.dmem_req_m     = if64.dmem_req_m;
  assign if4.md_done        = if64.md_done;
  assign if4.dmem_ready     = if64.dmem_ready;
  assign if4.cnt_clr        = if64.cnt_clr;

  logic [8:0] ctl64, ctl4;
  assign ctl64 = {if64.pc_en, if64.ifid_en, if64.idex_en, if64.exmem_en, if64.memwb_en,
                  if64.ifid_flush, if64.idex_flush, if64.exmem_flush, if64.memwb_flush};
  assign ctl4  = {if4.pc_en, if4.ifid_en, if4.idex_en, if4.exmem_en, if4.memwb_en,
                  if4.ifid_flush, if4.idex_flush, if4.exmem_flush, if4.memwb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    if64.rs_d = 5'd0; if64.rt_d = 5'd0; if64.branch_d = 1'b0;
    if64.branch_taken_d = 1'b0; if64.jump_d = 1'b0;
    if64.rt_e = 5'd0; if64.writereg_e = 5'd0; if64.memtoreg_e = 1'b0;
    if64.regwrite_e = 1'b0; if64.md_start_e = 1'b0;
    if64.writereg_m = 5'd0; if64.memtoreg_m = 1'b0; if64.dmem_req_m = 1'b0;
    if64.md_done = 1'b0; if64.dmem_ready = 1'b0; if64.cnt_clr = 1'b0;
  endtask

  // Advance one clock; st says whether the cycle just ending was a stall.
  task automatic tick(input bit st);
    @(posedge clk);
    #1;
    if (st && exp_sc != 16'hFFFF) exp_sc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_sc  = 16'd0;
    clr_inputs();
    reset_n = 1'b0;

    // Reset state
    #3;
    chk("rst_ctl",   32'(ctl64), 32'(C_OFF));
    chk("rst_state", 32'(if64.state), 32'd0);
    chk("rst_cnt",   32'(if64.stall_cycles), 32'd0);
    chk("rst_to",    32'(if64.md_timeout), 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;
    #1 chk("normal", 32'(ctl64), 32'(C_NORM));
    tick(0);

    // Load-use on rs
    if64.memtoreg_e = 1'b1; if64.rt_e = 5'd8; if64.rs_d = 5'd8;
    #1 chk("lu_rs", 32'(ctl64), 32'(C_HZ));
    tick(1);
    clr_inputs();
    #1 chk("lu_release", 32'(ctl64), 32'(C_NORM));
    chk("lu_cnt", 32'(if64.stall_cycles), 32'd1);
    tick(0);

    // Load to r0 is never a hazard
    if64.memtoreg_e = 1'b1;
    #1 chk("lu_r0", 32'(ctl64), 32'(C_NORM));
    tick(0);

    // Load-use on rt
    if64.rt_e = 5'd9; if64.rt_d = 5'd9; if64.rs_d = 5'd3;
    #1 chk("lu_rt", 32'(ctl64), 32'(C_HZ));
    tick(1);
    clr_inputs();

    // Branch hazard from EX; stall beats redirect
    if64.branch_d = 1'b1; if64.branch_taken_d = 1'b1;
    if64.regwrite_e = 1'b1; if64.writereg_e = 5'd5; if64.rt_d = 5'd5;
    #1 chk("br_ex", 32'(ctl64), 32'(C_HZ));
    tick(1);
    if64.writereg_e = 5'd0; if64.rt_d = 5'd0;
    #1 chk("br_ex_r0", 32'(ctl64), 32'(C_RDR));
    tick(0);

    // Branch hazard from a load in MEM
    if64.branch_taken_d = 1'b0; if64.regwrite_e = 1'b0;
    if64.memtoreg_m = 1'b1; if64.writereg_m = 5'd7; if64.rs_d = 5'd7;
    #1 chk("br_mem", 32'(ctl64), 32'(C_HZ));
    tick(1);
    if64.branch_d = 1'b0;
    #1 chk("nobr_mem", 32'(ctl64), 32'(C_NORM));
    tick(0);
    clr_inputs();

    // Taken branch and jump without hazard
    if64.branch_d = 1'b1; if64.branch_taken_d = 1'b1;
    #1 chk("br_taken", 32'(ctl64), 32'(C_RDR));
    tick(0);
    clr_inputs();
    if64.jump_d = 1'b1;
    #1 chk("jump", 32'(ctl64), 32'(C_RDR));
    tick(0);
    clr_inputs();

    // Memory stall over load-use, then load-use serviced
    if64.dmem_req_m = 1'b1; if64.memtoreg_e = 1'b1; if64.rt_e = 5'd8; if64.rs_d = 5'd8;
    #1 chk("prio_mem0", 32'(ctl64), 32'(C_MEM));
    tick(1);
    #1 chk("prio_mem1", 32'(ctl64), 32'(C_MEM));
    tick(1);
    if64.dmem_ready = 1'b1;
    #1 chk("prio_lu", 32'(ctl64), 32'(C_HZ));
    tick(1);
    clr_inputs();
    #1 chk("prio_done", 32'(ctl64), 32'(C_NORM));
    chk("prio_cnt", 32'(if64.stall_cycles), 32'(exp_sc));

    // Divide: start cycle 0, done cycle 5
    if64.md_start_e = 1'b1;
    #1 chk("div_c0_ctl", 32'(ctl64), 32'(C_MD));
    chk("div_c0_st", 32'(if64.state), 32'd0);
    tick(1);
    if64.md_start_e = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1 chk($sformatf("div_c%0d_st", c), 32'(if64.state), 32'd1);
      chk($sformatf("div_c%0d_ctl", c), 32'(ctl64), 32'(C_MD));
      tick(1);
    end
    if64.md_done = 1'b1;
    #1 chk("div_c5_st", 32'(if64.state), 32'd1);
    chk("div_c5_ctl", 32'(ctl64), 32'(C_NORM));
    tick(0);
    if64.md_done = 1'b0;
    #1 chk("div_end_st", 32'(if64.state), 32'd0);
    chk("div_end_ctl", 32'(ctl64), 32'(C_NORM));
    chk("div_end_to", 32'(if64.md_timeout), 32'd0);
    chk("div_cnt", 32'(if64.stall_cycles), 32'(exp_sc));

    // md_done while in RUN
    if64.md_done = 1'b1;
    #1 chk("done_run_ctl", 32'(ctl64), 32'(C_NORM));
    tick(0);
    if64.md_done = 1'b0;
    #1 chk("done_run_st", 32'(if64.state), 32'd0);

    // Timeout (MD_TIMEOUT=4) with a memory stall freezing the count
    do_reset();
    #1 chk("to_rst", 32'(if4.md_timeout), 32'd0);
    if64.md_start_e = 1'b1;
    #1 chk("to_c0", 32'(ctl4), 32'(C_MD));
    tick(0);
    if64.md_start_e = 1'b0;
    #1 chk("to_c1", 32'(ctl4), 32'(C_MD));
    tick(0);
    if64.dmem_req_m = 1'b1;
    for (int c = 2; c <= 3; c++) begin
      #1 chk($sformatf("to_c%0d_mem", c), 32'(ctl4), 32'(C_MEM));
      chk($sformatf("to_c%0d_st", c), 32'(if4.state), 32'd1);
      tick(0);
    end
    if64.dmem_req_m = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      #1 chk($sformatf("to_c%0d", c), 32'(ctl4), 32'(C_MD));
      tick(0);
    end
    #1 chk("to_c6_ctl", 32'(ctl4), 32'(C_NORM));
    chk("to_c6_st", 32'(if4.state), 32'd1);
    chk("to_c6_flag", 32'(if4.md_timeout), 32'd0);
    tick(0);
    #1 chk("to_c7_st", 32'(if4.state), 32'd0);
    chk("to_c7_flag", 32'(if4.md_timeout), 32'd1);
    repeat (5) tick(0);
    chk("to_sticky", 32'(if4.md_timeout), 32'd1);
    do_reset();
    chk("to_cleared", 32'(if4.md_timeout), 32'd0);

    // md_done coinciding with the timeout cycle
    if64.md_start_e = 1'b1;
    tick(0);
    if64.md_start_e = 1'b0;
    repeat (3) tick(0);
    if64.md_done = 1'b1;
    #1 chk("tie_ctl", 32'(ctl4), 32'(C_NORM));
    tick(0);
    if64.md_done = 1'b0;
    #1 chk("tie_st", 32'(if4.state), 32'd0);
    chk("tie_flag", 32'(if4.md_timeout), 32'd0);

    // Reset asserted mid-MD_BUSY
    if64.md_start_e = 1'b1;
    tick(0);
    if64.md_start_e = 1'b0;
    #1 chk("rbusy_pre", 32'(if4.state), 32'd1);
    reset_n = 1'b0;
    #1 chk("rbusy_ctl", 32'(ctl4), 32'(C_OFF));
    chk("rbusy_st", 32'(if4.state), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    #1 chk("rbusy_after_st", 32'(if4.state), 32'd0);
    chk("rbusy_after_ctl", 32'(ctl4), 32'(C_NORM));

    // Saturating stall counter and clear
    do_reset();
    if64.dmem_req_m = 1'b1;
    repeat (100) @(posedge clk);
    #1 chk("cnt_100", 32'(if64.stall_cycles), 32'd100);
    repeat (69900) @(posedge clk);
    #1 chk("cnt_sat", 32'(if64.stall_cycles), 32'hFFFF);
    if64.cnt_clr = 1'b1;
    @(posedge clk);
    #1 chk("cnt_clr", 32'(if64.stall_cycles), 32'd0);
    if64.cnt_clr = 1'b0;
    @(posedge clk);
    #1 chk("cnt_resume", 32'(if64.stall_cycles), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
